// File: rtl/chan_scan_pkg.sv
// chan_scan_pkg: shared mode constants and scan FSM state type for chan_scan_mux
package chan_scan_pkg;
  localparam logic MODE_MANUAL = 1'b0;
  localparam logic MODE_SCAN   = 1'b1;
  typedef enum logic [1:0] {IDLE, WAIT, HOLD} scan_state_t;
endpackage

// File: rtl/rr_next_enabled.sv
// rr_next_enabled: rotating-priority search for the first set mask bit from a start index
module rr_next_enabled #(
  parameter int N     = 16,
  parameter int SEL_W = $clog2(N)
) (
  input  logic [N-1:0]     mask_i,
  input  logic [SEL_W-1:0] start_i,
  input  logic             incl_i,
  output logic [SEL_W-1:0] idx_o,
  output logic             found_o
);
  always_comb begin
    idx_o   = '0;
    found_o = 1'b0;
    // Walk offsets from farthest to nearest so the nearest hit wins
    for (int k = N; k >= 1; k--) begin
      if (mask_i[(int'(start_i) + k - int'(incl_i)) % N]) begin
        idx_o   = SEL_W'((int'(start_i) + k - int'(incl_i)) % N);
        found_o = 1'b1;
      end
    end
  end
endmodule

// File: rtl/chan_scan_mux.sv
// chan_scan_mux: N-channel selector with manual select or masked round-robin scan into a handshaked output register
module chan_scan_mux
  import chan_scan_pkg::*;
#(
  parameter int WIDTH    = 1,
  parameter int CHANNELS = 16,
  parameter int SEL_W    = $clog2(CHANNELS),
  parameter int DWELL_W  = 16
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [CHANNELS*WIDTH-1:0] din,
  input  logic [SEL_W-1:0]          sel,
  input  logic                      mode,
  input  logic [CHANNELS-1:0]       enable_mask,
  input  logic [DWELL_W-1:0]        dwell,
  output logic [WIDTH-1:0]          dout,
  output logic [SEL_W-1:0]          dout_ch,
  output logic                      dout_valid,
  input  logic                      dout_ready
);
  scan_state_t        state_q, state_d;
  logic [SEL_W-1:0]   cur_ch_q, cur_ch_d, dout_ch_q, dout_ch_d, cap_ch, sel_eff;
  logic [SEL_W-1:0]   inc_idx, exc_idx;
  logic [DWELL_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0]   dout_q, dout_d;
  logic               valid_q, valid_d, inc_found, exc_found, free, xfer, cap;

  rr_next_enabled #(.N(CHANNELS), .SEL_W(SEL_W)) u_inc (
    .mask_i(enable_mask), .start_i(cur_ch_q), .incl_i(1'b1), .idx_o(inc_idx), .found_o(inc_found)
  );
  rr_next_enabled #(.N(CHANNELS), .SEL_W(SEL_W)) u_exc (
    .mask_i(enable_mask), .start_i(cur_ch_q), .incl_i(1'b0), .idx_o(exc_idx), .found_o(exc_found)
  );

  always_comb begin
    free     = !valid_q || dout_ready;
    xfer     = valid_q && dout_ready;
    sel_eff  = (int'(sel) < CHANNELS) ? sel : '0;
    state_d  = state_q;
    cur_ch_d = cur_ch_q;
    cnt_d    = cnt_q;
    cap      = 1'b0;
    cap_ch   = cur_ch_q;
    if (mode == MODE_MANUAL) begin
      state_d = IDLE;
      cap     = free;
      cap_ch  = sel_eff;
    end else begin
      case (state_q)
        IDLE: if (inc_found) begin
          cur_ch_d = inc_idx;
          cnt_d    = '0;
          state_d  = WAIT;
        end
        // >= keeps a live dwell decrease or a stalled register from skipping the sample
        WAIT: if (!enable_mask[cur_ch_q]) state_d = IDLE;
          else if (cnt_q >= dwell && free) begin
            cap     = 1'b1;
            state_d = HOLD;
          end else cnt_d = (&cnt_q) ? cnt_q : cnt_q + DWELL_W'(1);
        HOLD: if (xfer) begin
          cur_ch_d = exc_found ? exc_idx : cur_ch_q;
          cnt_d    = '0;
          state_d  = exc_found ? WAIT : IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
    dout_d    = cap ? din[int'(cap_ch)*WIDTH +: WIDTH] : dout_q;
    dout_ch_d = cap ? cap_ch : dout_ch_q;
    valid_d   = cap || (valid_q && !dout_ready);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      cur_ch_q  <= '0;
      cnt_q     <= '0;
      dout_q    <= '0;
      dout_ch_q <= '0;
      valid_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      cur_ch_q  <= cur_ch_d;
      cnt_q     <= cnt_d;
      dout_q    <= dout_d;
      dout_ch_q <= dout_ch_d;
      valid_q   <= valid_d;
    end
  end

  assign dout       = dout_q;
  assign dout_ch    = dout_ch_q;
  assign dout_valid = valid_q;
endmodule

// File: tb/tb_chan_scan_mux.sv
// tb_chan_scan_mux: directed checks of manual select, scan order/timing, backpressure, reset and a 5x8 instance
module tb_chan_scan_mux;
  import chan_scan_pkg::*;
  logic        clk = 0;
  logic        reset = 1;
  logic [15:0] din = '0, mask = '0, dwell = '0;
  logic [3:0]  sel = '0, dout_ch;
  logic        mode = 0, ready = 1, valid;
  logic [0:0]  dout;
  logic [39:0] din5 = '0;
  logic [4:0]  mask5 = '0;
  logic [15:0] dwell5 = '0;
  logic [2:0]  sel5 = '0, ch5;
  logic        mode5 = 0, ready5 = 1, valid5;
  logic [7:0]  dout5;
  int          total = 0, bad = 0;

  chan_scan_mux dut (
    .clk(clk), .reset(reset), .din(din), .sel(sel), .mode(mode), .enable_mask(mask),
    .dwell(dwell), .dout(dout), .dout_ch(dout_ch), .dout_valid(valid), .dout_ready(ready)
  );
  chan_scan_mux #(.WIDTH(8), .CHANNELS(5)) dut5 (
    .clk(clk), .reset(reset), .din(din5), .sel(sel5), .mode(mode5), .enable_mask(mask5),
    .dwell(dwell5), .dout(dout5), .dout_ch(ch5), .dout_valid(valid5), .dout_ready(ready5)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1;
    tick();
    tick();
    reset = 0;
  endtask

  task automatic test_reset();
    mode = MODE_MANUAL;
    din = 16'hFFFF;
    reset = 1;
    tick();
    tick();
    total++; if (valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%0b exp=0", valid); end
    total++; if (dout !== 1'b0) begin bad++; $display("FAIL reset_dout got=%0h exp=0", dout); end
    total++; if (dout_ch !== 4'd0) begin bad++; $display("FAIL reset_ch got=%0d exp=0", dout_ch); end
    total++; if (dut.state_q !== IDLE) begin bad++; $display("FAIL reset_state got=%0d exp=IDLE", dut.state_q); end
    reset = 0;
  endtask

  task automatic test_manual();
    logic [15:0] one = 16'h0001;
    mode = MODE_MANUAL;
    ready = 1;
    for (int s = 0; s < 16; s++) begin
      sel = 4'(s);
      din = one << s;
      tick();
      total++; if (dout !== 1'b1 || dout_ch !== 4'(s) || valid !== 1'b1)
        begin bad++; $display("FAIL manual_hi s=%0d got dout=%0h ch=%0d v=%0b exp 1/%0d/1", s, dout, dout_ch, valid, s); end
      din = ~(one << s);
      tick();
      total++; if (dout !== 1'b0 || dout_ch !== 4'(s) || valid !== 1'b1)
        begin bad++; $display("FAIL manual_lo s=%0d got dout=%0h ch=%0d v=%0b exp 0/%0d/1", s, dout, dout_ch, valid, s); end
    end
  endtask

  task automatic test_scan();
    mode = MODE_SCAN;
    mask = 16'h0005;
    dwell = 16'd3;
    ready = 1;
    din = 16'h0001;
    do_reset();
    for (int n = 1; n <= 21; n++) begin
      tick();
      total++; if (valid !== (n % 5 == 0))
        begin bad++; $display("FAIL scan_valid n=%0d got=%0b exp=%0b", n, valid, (n % 5 == 0)); end
      if (n % 5 == 0) begin
        total++; if (dout_ch !== (((n / 5) % 2 == 1) ? 4'd0 : 4'd2) || dout !== (((n / 5) % 2 == 1) ? 1'b1 : 1'b0))
          begin bad++; $display("FAIL scan_ch n=%0d got ch=%0d dout=%0h", n, dout_ch, dout); end
      end
    end
  endtask

  task automatic test_backpressure();
    mode = MODE_SCAN;
    mask = 16'h0003;
    dwell = 16'd0;
    ready = 0;
    din = 16'h0001;
    do_reset();
    tick();
    tick();
    total++; if (valid !== 1'b1 || dout_ch !== 4'd0 || dout !== 1'b1)
      begin bad++; $display("FAIL bp_first got v=%0b ch=%0d dout=%0h exp 1/0/1", valid, dout_ch, dout); end
    for (int i = 0; i < 10; i++) begin
      din = (i % 2 == 0) ? 16'h0000 : 16'hFFFE;
      tick();
      total++; if (valid !== 1'b1 || dout_ch !== 4'd0 || dout !== 1'b1)
        begin bad++; $display("FAIL bp_hold i=%0d got v=%0b ch=%0d dout=%0h exp 1/0/1", i, valid, dout_ch, dout); end
    end
    ready = 1;
    din = 16'h0002;
    tick();
    total++; if (valid !== 1'b0) begin bad++; $display("FAIL bp_drain got v=%0b exp 0", valid); end
    tick();
    total++; if (valid !== 1'b1 || dout_ch !== 4'd1 || dout !== 1'b1)
      begin bad++; $display("FAIL bp_next got v=%0b ch=%0d dout=%0h exp 1/1/1", valid, dout_ch, dout); end
  endtask

  task automatic test_mask_zero();
    int n = 0;
    mode = MODE_SCAN;
    mask = 16'h0000;
    dwell = 16'd2;
    ready = 1;
    din = 16'h0100;
    do_reset();
    for (int i = 0; i < 50; i++) begin
      tick();
      total++; if (valid !== 1'b0) begin bad++; $display("FAIL mask0_valid i=%0d got=%0b exp=0", i, valid); end
    end
    mask = 16'h0100;
    while (valid !== 1'b1 && n < 8) begin
      tick();
      n++;
    end
    total++; if (n != 4) begin bad++; $display("FAIL mask0_latency got=%0d exp=4", n); end
    total++; if (dout_ch !== 4'd8 || dout !== 1'b1)
      begin bad++; $display("FAIL mask0_ch got ch=%0d dout=%0h exp 8/1", dout_ch, dout); end
  endtask

  task automatic test_reset_hold();
    mode = MODE_SCAN;
    mask = 16'h0001;
    dwell = 16'd0;
    ready = 0;
    din = 16'h0001;
    do_reset();
    tick();
    tick();
    total++; if (dut.state_q !== HOLD || valid !== 1'b1)
      begin bad++; $display("FAIL rsthold_pre got state=%0d v=%0b exp HOLD/1", dut.state_q, valid); end
    reset = 1;
    tick();
    total++; if (valid !== 1'b0 || dout !== 1'b0 || dout_ch !== 4'd0 || dut.state_q !== IDLE)
      begin bad++; $display("FAIL rsthold_post got v=%0b dout=%0h ch=%0d state=%0d exp 0/0/0/IDLE", valid, dout, dout_ch, dut.state_q); end
    reset = 0;
  endtask

  task automatic test_mode_switch();
    mode = MODE_SCAN;
    mask = 16'h0004;
    dwell = 16'd0;
    ready = 0;
    din = 16'h0004;
    do_reset();
    tick();
    tick();
    mode = MODE_MANUAL;
    sel = 4'd5;
    din = 16'h0000;
    tick();
    tick();
    total++; if (valid !== 1'b1 || dout_ch !== 4'd2 || dout !== 1'b1)
      begin bad++; $display("FAIL switch_hold got v=%0b ch=%0d dout=%0h exp 1/2/1", valid, dout_ch, dout); end
    ready = 1;
    tick();
    total++; if (valid !== 1'b1 || dout_ch !== 4'd5 || dout !== 1'b0)
      begin bad++; $display("FAIL switch_manual got v=%0b ch=%0d dout=%0h exp 1/5/0", valid, dout_ch, dout); end
  endtask

  task automatic test_ch5();
    logic [7:0] exp_d;
    logic [2:0] exp_c;
    mode5 = MODE_SCAN;
    mask5 = 5'b10001;
    dwell5 = 16'd1;
    ready5 = 1;
    din5 = {8'hA5, 8'h33, 8'h22, 8'h11, 8'h3C};
    do_reset();
    for (int n = 1; n <= 9; n++) begin
      tick();
      total++; if (valid5 !== (n % 3 == 0))
        begin bad++; $display("FAIL ch5_valid n=%0d got=%0b exp=%0b", n, valid5, (n % 3 == 0)); end
      if (n % 3 == 0) begin
        exp_d = (n == 6) ? 8'hA5 : 8'h3C;
        exp_c = (n == 6) ? 3'd4 : 3'd0;
        total++; if (dout5 !== exp_d || ch5 !== exp_c)
          begin bad++; $display("FAIL ch5_scan n=%0d got dout=%0h ch=%0d exp %0h/%0d", n, dout5, ch5, exp_d, exp_c); end
      end
    end
    mode5 = MODE_MANUAL;
    sel5 = 3'd7;
    tick();
    tick();
    total++; if (dout5 !== 8'h3C || ch5 !== 3'd0 || valid5 !== 1'b1)
      begin bad++; $display("FAIL ch5_sel7 got dout=%0h ch=%0d v=%0b exp 3c/0/1", dout5, ch5, valid5); end
    sel5 = 3'd3;
    tick();
    total++; if (dout5 !== 8'h33 || ch5 !== 3'd3)
      begin bad++; $display("FAIL ch5_sel3 got dout=%0h ch=%0d exp 33/3", dout5, ch5); end
  endtask

  initial begin
    test_reset();
    test_manual();
    test_scan();
    test_backpressure();
    test_mask_zero();
    test_reset_hold();
    test_mode_switch();
    test_ch5();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/chan_scan_mux.md
# chan_scan_mux

Parametrised N-channel, W-bit selector with a registered, handshaked output. It is the successor to the fixed 16:1 1-bit gate-level selector. Two modes are supported: manual select, where any channel is chosen by `sel`, and auto-scan, where the block steps round-robin through a masked set of channels with a programmable dwell. It sits between the key/tone-source inputs and downstream consumers such as the note encoder and the audio mixer.

## Interface
Parameters:
- `WIDTH`, 1: bits per channel.
- `CHANNELS`, 16: number of inputs; must be ≥2.
- `SEL_W`, $clog2(CHANNELS): channel index width.
- `DWELL_W`, 16: dwell counter width.

Ports:
- `clk` in 1: sole clock; all logic is on the rising edge.
- `reset` in 1: synchronous, active-high.
- `din` in CHANNELS*WIDTH: channel k occupies bits [k*WIDTH +: WIDTH].
- `sel` in SEL_W: manual channel index; values ≥CHANNELS select channel 0.
- `mode` in 1: 0 = manual, 1 = scan.
- `enable_mask` in CHANNELS: scan participation, one bit per channel; ignored in manual mode.
- `dwell` in DWELL_W: scan wait, in cycles, before each sample.
- `dout` out WIDTH: captured channel data.
- `dout_ch` out SEL_W: index of the captured channel.
- `dout_valid` out 1: output register holds unconsumed data.
- `dout_ready` in 1: consumer accepts; a transfer occurs when valid && ready on the same edge.

## Operation
- Reset state:
  - state IDLE, `cur_ch`=0, `cnt`=0.
  - `dout`=0, `dout_ch`=0, `dout_valid`=0.
- The output register is "free" when `dout_valid`=0 or `dout_ready`=1.
- Manual mode (`mode`=0): each cycle the register is free, capture `din[sel]` and `sel` and set `dout_valid`=1. If the register is not free, hold. The FSM is forced to IDLE.
- Scan mode (`mode`=1), FSM {IDLE, WAIT, HOLD}:
  - IDLE:
    - If `enable_mask`≠0: set `cur_ch` = first enabled channel at or after `cur_ch` (wrapping), `cnt`=0, go to WAIT.
    - Otherwise stay in IDLE.
  - WAIT: `cnt`++.
    - When `cnt`==`dwell` and the register is free: capture `din[cur_ch]` and `cur_ch`, set `dout_valid`=1, go to HOLD.
    - If `enable_mask[cur_ch]` drops during WAIT, go to IDLE without capturing.
  - HOLD: on transfer:
    - Set `cur_ch` = next enabled channel strictly after `cur_ch` (wrapping; this may be `cur_ch` itself if it is the only one), `cnt`=0, go to WAIT.
    - If the mask is now 0, go to IDLE.
- Transfer without a new capture clears `dout_valid` the next cycle.
- Switching `mode` mid-operation:
  - A pending valid word is held until it is transferred; it is never dropped or overwritten.
  - The new mode takes effect on the next capture.
  - Entering scan starts from IDLE with the current `cur_ch`.
- `dwell` and `enable_mask` are sampled live; they are not latched per channel.
- `reset` in any state returns to the reset values on the next edge and discards the pending word.

## Timing
- Manual latency: `din`/`sel` to `dout` is 1 cycle. With `dout_ready`=1, `dout_valid` stays high continuously from cycle 1 after reset release.
- Scan with `dout_ready` held 1 and dwell D:
  - IDLE→WAIT takes 1 cycle; WAIT lasts D+1 cycles; `dout_valid` is a 1-cycle pulse.
  - Channel period is D+2 cycles. `dwell`=0 gives a period of 2.
- Backpressure: `dout`, `dout_ch`, and `dout_valid` are stable while valid && !ready.
- `cnt` saturates at its maximum; it never wraps.

## Structure
- Shared package `chan_scan_pkg`:
  - Mode constants `MODE_MANUAL`=0 and `MODE_SCAN`=1.
  - State enum `scan_state_t` {IDLE, WAIT, HOLD}.
- Sub-module `rr_next_enabled`:
  - Combinational rotating-priority finder.
  - Inputs: mask, start index, inclusive flag. Outputs: index, found.
  - Used for both IDLE (inclusive) and HOLD (exclusive) searches.
- Top level: FSM, dwell counter, indexed-part-select data mux, output register.

## Test plan
- Manual, defaults, `dout_ready`=1: sweep `sel` 0..15 with one-hot `din`. `dout`=`din[sel]` and `dout_ch`=`sel` one cycle later. `sel`=15 with `din`=16'h8000 gives `dout`=1.
- Scan, `enable_mask`=16'h0005, `dwell`=3, ready=1: `dout_ch` sequence is 0,2,0,2…, with valid pulses exactly 5 cycles apart.
- Backpressure: scan, mask 16'h0003, `dwell`=0. Hold ready=0 for 10 cycles while `din` changes. `dout` is frozen at the first sample; after ready=1 the next `dout_ch` is 1.
- Mask 0 in scan: `dout_valid` stays 0 for 50 cycles. Setting the mask to 16'h0100 gives the first valid with `dout_ch`=8 within `dwell`+2 cycles.
- Reset mid-HOLD with a pending word: the next cycle has `dout_valid`=0, `dout`=0, `dout_ch`=0, and state IDLE.
- `WIDTH`=8, `CHANNELS`=5, scan, mask 5'b10001, `din` ch4=8'hA5 and ch0=8'h3C: wrap order 0,4,0. The `dout` values are 3C, A5, 3C; `sel`=7 in manual selects ch0.
